// File: rtl/biquad8_output_stage_if.sv
// Data/control bundle between the biquad8 filter chain, this output stage and its consumer.
// The master side drives the sample vectors and control pulses; the slave side is the output stage.
interface biquad8_output_stage_if #(
  parameter int NSAMP    = 8,
  parameter int INBITS   = 16,
  parameter int OUTBITS  = 12,
  parameter int CNT_BITS = 16
);
  logic                      enable_i;
  logic                      update_i;
  logic                      sat_clear_i;
  logic [INBITS*NSAMP-1:0]   filt_i;
  logic [INBITS*NSAMP-1:0]   raw_i;
  logic [OUTBITS*NSAMP-1:0]  dat_o;
  logic [NSAMP-1:0]          sat_o;
  logic [1:0]                state_o;
  logic [CNT_BITS-1:0]       sat_count_o;

  modport master (
    output enable_i, update_i, sat_clear_i, filt_i, raw_i,
    input  dat_o, sat_o, state_o, sat_count_o
  );

  modport slave (
    input  enable_i, update_i, sat_clear_i, filt_i, raw_i,
    output dat_o, sat_o, state_o, sat_count_o
  );
endinterface

// File: rtl/biquad8_output_stage.sv
// Output stage after the biquad8 chain: raw/filtered select with settle hold, round + saturate per sample.
// Optional saturation event counter is built only when BIQUAD8_OUT_SAT_COUNT_EN is defined.
module biquad8_output_stage #(
  parameter int NSAMP         = 8,
  parameter int INBITS        = 16,
  parameter int INFRAC        = 2,
  parameter int OUTBITS       = 12,
  parameter int OUTFRAC       = 0,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_BITS      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  biquad8_output_stage_if.slave   bus
);

  localparam int SH  = INFRAC - OUTFRAC;
  localparam int WB  = INBITS + 1;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SCW-1:0]       SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
  localparam logic signed [WB-1:0] RND  = WB'(1) <<< (SH - 1);
  localparam logic signed [WB-1:0] VMAX = {{(WB-OUTBITS+1){1'b0}}, {(OUTBITS-1){1'b1}}};
  localparam logic signed [WB-1:0] VMIN = {{(WB-OUTBITS+1){1'b1}}, {(OUTBITS-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                   state_q;
  logic [SCW-1:0]           settle_q;
  logic [INBITS*NSAMP-1:0]  sel_q;
  logic [OUTBITS*NSAMP-1:0] dat_q;
  logic [OUTBITS*NSAMP-1:0] dat_d;
  logic [NSAMP-1:0]         sat_q;
  logic [NSAMP-1:0]         sat_d;

  // Disable dominates everything; an update restarts the settle window from any enabled state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_BYPASS;
      settle_q <= '0;
    end else if (!bus.enable_i) begin
      state_q <= ST_BYPASS;
    end else begin
      case (state_q)
        ST_BYPASS: begin
          state_q  <= ST_SETTLE;
          settle_q <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (bus.update_i) begin
            settle_q <= SETTLE_LOAD;
          end else if (settle_q == '0) begin
            state_q <= ST_RUN;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.update_i) begin
            state_q  <= ST_SETTLE;
            settle_q <= SETTLE_LOAD;
          end
        end
        default: state_q <= ST_BYPASS;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q <= '0;
      dat_q <= '0;
      sat_q <= '0;
    end else begin
      sel_q <= (state_q == ST_RUN) ? bus.filt_i : bus.raw_i;
      dat_q <= dat_d;
      sat_q <= sat_d;
    end
  end

  // One extra bit of headroom keeps the rounding add from wrapping at full-scale positive input.
  for (genvar gi = 0; gi < NSAMP; gi++) begin : g_samp
    logic signed [WB-1:0] x_ext;
    logic signed [WB-1:0] sum_w;
    logic signed [WB-1:0] v_w;
    logic [OUTBITS-1:0]   d_s;
    logic                 s_s;

    assign x_ext = {sel_q[gi*INBITS+INBITS-1], sel_q[gi*INBITS +: INBITS]};
    assign sum_w = x_ext + RND;
    assign v_w   = sum_w >>> SH;

    always_comb begin
      d_s = v_w[OUTBITS-1:0];
      s_s = 1'b0;
      if (v_w > VMAX) begin
        d_s = VMAX[OUTBITS-1:0];
        s_s = 1'b1;
      end else if (v_w < VMIN) begin
        d_s = VMIN[OUTBITS-1:0];
        s_s = 1'b1;
      end
    end

    assign dat_d[gi*OUTBITS +: OUTBITS] = d_s;
    assign sat_d[gi]                    = s_s;
  end

`ifdef BIQUAD8_OUT_SAT_COUNT_EN
  logic [CNT_BITS-1:0] sat_cnt_q;

  // Counts alongside sat_q being loaded, so the count and the flag appear on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_cnt_q <= '0;
    end else if (bus.sat_clear_i) begin
      sat_cnt_q <= '0;
    end else if ((|sat_d) && (sat_cnt_q != {CNT_BITS{1'b1}})) begin
      sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

  assign bus.sat_count_o = sat_cnt_q;
`else
  logic unused_sat_clear;
  assign unused_sat_clear = bus.sat_clear_i;
  assign bus.sat_count_o  = '0;
`endif

  assign bus.dat_o   = dat_q;
  assign bus.sat_o   = sat_q;
  assign bus.state_o = state_q;

endmodule

// File: doc/biquad8_output_stage.md
Name: biquad8_output_stage

Overview:
- Data-side stage directly downstream of the biquad8 filter chain. Consumes the NSAMP-wide filtered sample vector and a matching unfiltered (raw) vector.
- Outputs the raw vector while the filter is disabled and while the IIR settles after enable or a coefficient update. Outputs the filtered vector otherwise.
- Rounds and saturates the selected path to OUTBITS per sample and reports saturation events to the control side.

Parameters:
NSAMP, 8, samples per clock
INBITS, 16, input sample width (both paths)
INFRAC, 2, input fractional bits; must satisfy INFRAC > OUTFRAC
OUTBITS, 12, output sample width
OUTFRAC, 0, output fractional bits
SETTLE_CYCLES, 64, clocks the raw path is held after enable/update; must be >= 1
CNT_BITS, 16, saturation counter width

Ports:
clk_i  in  1  data clock (same domain as the filter clk_i)
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  level; 1 = filter path requested, 0 = bypass
update_i  in  1  single-cycle pulse; coefficient update just applied to the filter
filt_i  in  INBITS*NSAMP  filtered samples, sample 0 in LSBs
raw_i  in  INBITS*NSAMP  unfiltered samples, time-aligned to filt_i
sat_clear_i  in  1  single-cycle pulse; clears sat_count_o
dat_o  out  OUTBITS*NSAMP  rounded, saturated output samples
sat_o  out  NSAMP  per-sample saturation flag, aligned with dat_o
state_o  out  2  current FSM state: 0 BYPASS, 1 SETTLE, 2 RUN
sat_count_o  out  CNT_BITS  count of cycles with any saturation

Behaviour:
- Reset (rst_ni low, asynchronous): state = BYPASS, settle counter = 0. dat_o, sat_o, sat_count_o and all pipeline registers = 0. Outputs are valid from the first rising edge after release.
- FSM, evaluated on each rising edge, in priority order:
  1. enable_i = 0 -> BYPASS, from any state.
  2. In BYPASS with enable_i = 1 -> SETTLE; counter loads SETTLE_CYCLES-1.
  3. In SETTLE or RUN with update_i = 1 -> SETTLE; counter reloads SETTLE_CYCLES-1.
  4. In SETTLE with counter = 0 -> RUN. Otherwise in SETTLE, counter decrements.
  5. RUN holds.
- Consequences of the priority order:
  - enable_i falling in the same cycle as update_i -> BYPASS.
  - update_i while in BYPASS is ignored.
- Settle length: SETTLE lasts exactly SETTLE_CYCLES clocks, so state_o = 1 for SETTLE_CYCLES consecutive cycles.
- Path select:
  - Stage 1 registers the selected vector: filt_i when the registered state is RUN, raw_i otherwise.
  - The select is switched by the state register value, so the path changes on the cycle after state_o changes.
- Per-sample arithmetic, stage 2, on signed values with SH = INFRAC-OUTFRAC:
  - v = (x + 2^(SH-1)) >>> SH, arithmetic shift (round half up), computed without overflow at INBITS+1 bits.
  - If v > 2^(OUTBITS-1)-1, output the max and set sat bit.
  - If v < -2^(OUTBITS-1), output the min and set sat bit.
  - Otherwise output v[OUTBITS-1:0] and clear sat bit.
- Latency: 2 clocks from filt_i/raw_i to dat_o/sat_o. Fully pipelined; one vector accepted per clock; no stall.
- sat_o is recomputed every cycle (not sticky).
- sat_count_o:
  - Increments by 1 on each cycle in which any bit of sat_o is (being registered as) 1.
  - Saturates at all-ones; no wrap.
  - sat_clear_i clears to 0. If sat_clear_i coincides with an increment, clear wins and the result is 0.
- Reset mid-operation: everything returns to reset values immediately. After release the FSM restarts from BYPASS, so a full settle is required again.

Optional Feature:
BIQUAD8_OUT_SAT_COUNT_EN
- Defined: the saturation counter and sat_clear_i logic are implemented as described above.
- Undefined:
  - No counter logic is instantiated; sat_count_o is tied to 0 and sat_clear_i is ignored.
  - sat_o, the FSM and the datapath are unchanged.

Test Plan:
1. Reset, then enable_i = 0. Drive raw_i sample0 = 6, sample1 = -6, sample2 = -8 -> two clocks later dat_o samples = 2, -1, -2; sat_o = 0; state_o = 0.
2. enable_i 0->1 with SETTLE_CYCLES = 64, filt_i all 100, raw_i all 200 -> state_o = 1 for exactly 64 cycles, then 2. dat_o = 50 through SETTLE, then 25 starting 2 clocks after the first RUN-state select.
3. In RUN, pulse update_i -> state_o = 1 next cycle for 64 cycles; raw path on dat_o again. Pulse enable_i low together with update_i -> state_o = 0.
4. Select filtered path, drive filt_i sample3 = 0x7FFF, sample4 = 0x8000 -> dat_o sample3 = 2047, sample4 = -2048, sat_o = 0x18. Hold for 5 cycles -> sat_count_o = 5.
5. sat_clear_i in the same cycle as a saturating vector -> sat_count_o = 0, then 1 on the following saturating cycle. With CNT_BITS = 4 and 20 saturating cycles -> sat_count_o = 15.
6. Assert rst_ni low mid-SETTLE -> all outputs 0 asynchronously; after release with enable_i = 1, state_o goes 0 -> 1, followed by a full 64-cycle settle. Rebuild without BIQUAD8_OUT_SAT_COUNT_EN -> scenario 4 gives sat_count_o = 0 and sat_o = 0x18.
